crtc_gen2: RTL and testbench

- Programmable video timing generator: second-generation CRTC for the video pipeline.
- Generates pixel clock-enable, horizontal/vertical counters, blank and sync signals from a 16x16 CPU register file.
- Adds over the first generation:
  - parametrised counter width
  - built-in fractional clock-enable
  - frame-boundary double-buffering of timing registers
  - sync polarity control
  - interlace
  - line-compare interrupt

---
 rtl/crtc_gen2_if.sv | 10 +
 rtl/crtc_gen2.sv | 170 +++++++++++++++++
 tb/tb_crtc_gen2.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crtc_gen2_if.sv
// CPU register-file bus for the video timing generator.
interface crtc_gen2_if;
    logic [1:0]  wr;
    logic [3:0]  address;
    logic [15:0] din;
    logic [15:0] dout;

    modport master (output wr, output address, output din, input dout);
    modport slave  (input wr, input address, input din, output dout);
endinterface

// File: rtl/crtc_gen2.sv
// Programmable video timing generator with a fractional pixel clock-enable,
// frame-boundary shadowing of the timing registers, sync polarity control,
// interlace and a line-compare interrupt.
module crtc_gen2 #(
    parameter int CW = 12,
    parameter int FW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    crtc_gen2_if.slave    bus,
    output logic          ce_pixel,
    output logic          hsync,
    output logic          hblank,
    output logic [CW-1:0] hcnt,
    output logic          vsync,
    output logic          vblank,
    output logic [CW-1:0] vcnt,
    output logic          field,
    output logic          irq
);
    localparam int H_START     = 2;
    localparam int H_END       = 3;
    localparam int HACT_END    = 4;
    localparam int HSYNC_START = 5;
    localparam int HSYNC_END   = 6;
    localparam int V_START     = 7;
    localparam int V_END       = 8;
    localparam int VACT_END    = 9;
    localparam int VSYNC_START = 10;
    localparam int VSYNC_END   = 11;

    logic [FW-1:0] num_p, den_p, num_a, den_a;
    logic [CW-1:0] tim_p [2:11];
    logic [CW-1:0] tim_a [2:11];
    logic [4:0]    ctrl;
    logic [CW-1:0] irq_line;
    logic          irq_pending;
    logic [FW:0]   acc;
    logic [FW+1:0] acc_sum;
    logic [15:0]   wmerge;
    logic          unused_bits;

    logic          enable, advance, h_wrap, v_wrap, frame_end, line_tick;
    logic          irq_set, irq_clr;
    logic [CW:0]   v_last;
    logic [CW-1:0] v_next;

    assign enable      = ctrl[0];
    assign unused_bits = ^wmerge;

    // Register read-back: timing regs report the CPU-written (pending) value.
    always_comb begin
        bus.dout = '0;
        case (bus.address)
            4'd0:    bus.dout = 16'(num_p);
            4'd1:    bus.dout = 16'(den_p);
            4'd12:   bus.dout = 16'(hcnt);
            4'd13:   bus.dout = 16'(vcnt);
            4'd14:   bus.dout = {field, irq_pending, 9'd0, ctrl};
            4'd15:   bus.dout = 16'(irq_line);
            default: bus.dout = 16'(tim_p[bus.address]);
        endcase
    end

    // Byte-lane merge of write data with the current register contents.
    always_comb begin
        wmerge = {bus.wr[1] ? bus.din[15:8] : bus.dout[15:8],
                  bus.wr[0] ? bus.din[7:0]  : bus.dout[7:0]};
    end

    // CPU-side register file (pending bank, CTRL, irq_line).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_p    <= '0;
            den_p    <= '0;
            ctrl     <= '0;
            irq_line <= '0;
            for (int i = 2; i <= 11; i++) tim_p[i] <= '0;
        end else if (|bus.wr) begin
            case (bus.address)
                4'd0:        num_p    <= wmerge[FW-1:0];
                4'd1:        den_p    <= wmerge[FW-1:0];
                4'd12, 4'd13: ;
                4'd14:       ctrl     <= wmerge[4:0];
                4'd15:       irq_line <= wmerge[CW-1:0];
                default:     tim_p[bus.address] <= wmerge[CW-1:0];
            endcase
        end
    end

    // Active bank follows pending while stopped, otherwise only at frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_a <= '0;
            den_a <= '0;
            for (int i = 2; i <= 11; i++) tim_a[i] <= '0;
        end else if (!enable || frame_end) begin
            num_a <= num_p;
            den_a <= den_p;
            tim_a <= tim_p;
        end
    end

    // Sum is one bit wider than the accumulator so the compare never wraps.
    always_comb begin
        acc_sum = (FW+2)'(acc) + (FW+2)'(num_a);
    end

    // Fractional clock-enable: free-running, independent of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            ce_pixel <= 1'b0;
        end else if (num_a == '0 || den_a == '0) begin
            ce_pixel <= 1'b0;
        end else if (acc_sum >= (FW+2)'(den_a)) begin
            acc      <= (FW+1)'(acc_sum - (FW+2)'(den_a));
            ce_pixel <= 1'b1;
        end else begin
            acc      <= (FW+1)'(acc_sum);
            ce_pixel <= 1'b0;
        end
    end

    // Wrap decisions; >= lets a shrunk h_end/v_end recover on the next tick.
    always_comb begin
        advance   = enable && ce_pixel;
        h_wrap    = hcnt >= tim_a[H_END];
        v_last    = {1'b0, tim_a[V_END]} + {{CW{1'b0}}, ctrl[3] & field};
        v_wrap    = {1'b0, vcnt} >= v_last;
        v_next    = v_wrap ? '0 : vcnt + 1'b1;
        line_tick = advance && h_wrap;
        frame_end = line_tick && v_wrap;
        irq_set   = line_tick && (v_next == irq_line);
        irq_clr   = bus.wr[1] && (bus.address == 4'd14) && bus.din[14];
    end

    // Horizontal/vertical counters and interlace field.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt  <= '0;
            vcnt  <= '0;
            field <= 1'b0;
        end else if (advance) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_next;
                if (v_wrap) field <= ctrl[3] ? ~field : 1'b0;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Line-compare interrupt latch; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     irq_pending <= 1'b0;
        else if (irq_set) irq_pending <= 1'b1;
        else if (irq_clr) irq_pending <= 1'b0;
    end

    // Blank/sync decode from counters, active bank and polarity bits.
    always_comb begin
        hblank = (hcnt > tim_a[HACT_END]) || (hcnt < tim_a[H_START]);
        hsync  = ((hcnt > tim_a[HSYNC_START]) && (hcnt <= tim_a[HSYNC_END])) ^ ctrl[1];
        vblank = (vcnt > tim_a[VACT_END]) || (vcnt < tim_a[V_START]);
        vsync  = ((vcnt > tim_a[VSYNC_START]) && (vcnt <= tim_a[VSYNC_END])) ^ ctrl[2];
        irq    = irq_pending & ctrl[4];
    end
endmodule

// File: tb/tb_crtc_gen2.sv
// Directed bench for crtc_gen2 with a queue scoreboard and a cycle model of
// the counters, field, shadowed h_end/v_end and the line interrupt.
module tb_crtc_gen2;
    localparam int CW = 12;
    localparam int FW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce_pixel, hsync, hblank, vsync, vblank, field, irq;
    logic [CW-1:0] hcnt, vcnt;

    always #5 clk = ~clk;

    crtc_gen2_if bus ();

    crtc_gen2 #(.CW(CW), .FW(FW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .ce_pixel(ce_pixel), .hsync(hsync), .hblank(hblank), .hcnt(hcnt),
        .vsync(vsync), .vblank(vblank), .vcnt(vcnt), .field(field), .irq(irq)
    );

    typedef struct { string tag; logic [31:0] exp; } sb_t;
    sb_t sbq[$];
    int total = 0;
    int bad   = 0;

    // reference model state
    int m_h, m_v, m_hend_a, m_hend_p, m_vend_a, m_vend_p, m_irqline;
    bit m_en, m_inv_h, m_il, m_irqen, m_field, m_irqp;
    // write currently on the bus
    bit w_act; logic [3:0] w_addr; logic [15:0] w_data; logic [1:0] w_mask;

    task automatic push_exp(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag; s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        sb_t s;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_empty observed=%0h expected=none", obs);
            return;
        end
        s = sbq.pop_front();
        assert (obs === s.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", s.tag, obs, s.exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        check_pop(obs);
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_hend_a = 0; m_hend_p = 0; m_vend_a = 0; m_vend_p = 0;
        m_irqline = 0; m_en = 0; m_inv_h = 0; m_il = 0; m_irqen = 0;
        m_field = 0; m_irqp = 0;
    endtask

    // One active clock edge; assumes ce_pixel is high every clk once enabled.
    task automatic model_step(input bit clr);
        bit hw, vw, fe, set;
        int vl, nv;
        fe = 0; set = 0;
        if (m_en) begin
            hw = (m_h >= m_hend_a);
            vl = m_vend_a + ((m_il && m_field) ? 1 : 0);
            vw = (m_v >= vl);
            if (hw) begin
                fe  = vw;
                nv  = vw ? 0 : m_v + 1;
                set = (nv == m_irqline);
                if (vw) m_field = m_il ? !m_field : 1'b0;
                m_v = nv;
                m_h = 0;
            end else begin
                m_h = m_h + 1;
            end
        end
        if (!m_en || fe) begin
            m_hend_a = m_hend_p;
            m_vend_a = m_vend_p;
        end
        if (set) m_irqp = 1;
        else if (clr) m_irqp = 0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
        case (a)
            4'd3:  m_hend_p = int'(d);
            4'd8:  m_vend_p = int'(d);
            4'd14: if (m[0]) begin
                       m_en = d[0]; m_inv_h = d[1]; m_il = d[3]; m_irqen = d[4];
                   end
            4'd15: m_irqline = int'(d);
            default: ;
        endcase
    endtask

    // Fixed geometry: hact_end 7, hsync 8..9, vact_end 3, vsync 3..4, starts 0.
    function automatic logic [29:0] model_vec();
        logic hb, hs, vb, vs;
        hb = (m_h > 7);
        hs = ((m_h > 8) && (m_h <= 9)) ^ m_inv_h;
        vb = (m_v > 3);
        vs = (m_v > 3) && (m_v <= 4);
        return {12'(m_h), 12'(m_v), hb, hs, vb, vs, m_field, m_irqp & m_irqen};
    endfunction

    task automatic tick(input bit do_chk);
        bit clr;
        @(posedge clk);
        clr = w_act && (w_addr == 4'd14) && w_mask[1] && w_data[14];
        model_step(clr);
        if (w_act) model_write(w_addr, w_data, w_mask);
        #1;
        if (do_chk) begin
            push_exp("frame", {2'b00, model_vec()});
            check_pop({2'b00, hcnt, vcnt, hblank, hsync, vblank, vsync, field, irq});
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m, input bit do_chk);
        bus.wr = m; bus.address = a; bus.din = d;
        w_act = 1; w_addr = a; w_data = d; w_mask = m;
        tick(do_chk);
        bus.wr = 2'b00; w_act = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] e);
        bus.address = a;
        #1;
        chk(tag, {16'd0, bus.dout}, {16'd0, e});
    endtask

    task automatic run(input int n, input bit do_chk);
        for (int i = 0; i < n; i++) tick(do_chk);
    endtask

    task automatic wait_model(input string tag, input int h, input int v);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v) && n < 300) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, n < 300}, 32'd1);
    endtask

    task automatic count_ce(input int n, output int cnt, output int gap_bad);
        int last;
        cnt = 0; gap_bad = 0; last = -1;
        for (int i = 0; i < n; i++) begin
            tick(0);
            if (ce_pixel) begin
                if (last >= 0 && (i - last) != 3) gap_bad++;
                last = i;
                cnt++;
            end
        end
    endtask

    int cnt, gb, n_f1, n_f0;

    initial begin
        bus.wr = 2'b00; bus.address = 4'd0; bus.din = 16'd0;
        w_act = 0; w_addr = 0; w_data = 0; w_mask = 0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {22'd0, ce_pixel, hblank, hsync, vblank, vsync, field, irq, 3'd0}, 32'd0);
        chk("rst_cnt", {8'd0, hcnt, vcnt}, 32'd0);
        rd_chk("rst_dout14", 4'd14, 16'd0);
        rd_chk("rst_dout3", 4'd3, 16'd0);
        reset_n = 1'b1;

        // fractional clock-enable
        wr_reg(4'd0, 16'd1, 2'b11, 0);
        wr_reg(4'd1, 16'd3, 2'b11, 0);
        run(3, 0);
        count_ce(30, cnt, gb);
        chk("ce_1_3_count", cnt, 10);
        chk("ce_1_3_gaps", gb, 0);
        rd_chk("rd_denom", 4'd1, 16'd3);
        wr_reg(4'd0, 16'd0, 2'b11, 0);
        run(3, 0);
        count_ce(12, cnt, gb);
        chk("ce_num0", cnt, 0);
        wr_reg(4'd0, 16'd4, 2'b11, 0);
        run(3, 0);
        count_ce(10, cnt, gb);
        chk("ce_num_gt_den", cnt, 10);
        wr_reg(4'd1, 16'd0, 2'b11, 0);
        run(3, 0);
        count_ce(10, cnt, gb);
        chk("ce_den0", cnt, 0);

        // frame timing setup
        reset_n = 1'b0;
        model_reset();
        #3 reset_n = 1'b1;
        wr_reg(4'd0, 16'd1, 2'b11, 0);
        wr_reg(4'd1, 16'd1, 2'b11, 0);
        run(3, 0);
        wr_reg(4'd2,  16'd0, 2'b11, 0);
        wr_reg(4'd3,  16'd9, 2'b11, 0);
        wr_reg(4'd4,  16'd7, 2'b11, 0);
        wr_reg(4'd5,  16'd8, 2'b11, 0);
        wr_reg(4'd6,  16'd9, 2'b11, 0);
        wr_reg(4'd7,  16'd0, 2'b11, 0);
        wr_reg(4'd8,  16'd4, 2'b11, 0);
        wr_reg(4'd9,  16'd3, 2'b11, 0);
        wr_reg(4'd10, 16'd3, 2'b11, 0);
        wr_reg(4'd11, 16'd4, 2'b11, 0);
        wr_reg(4'd12, 16'd7, 2'b11, 0);
        run(2, 0);
        chk("ro_hcnt_ignored", {20'd0, hcnt}, 32'd0);
        wr_reg(4'd14, 16'h0001, 2'b11, 1);
        run(110, 1);

        // sync polarity
        wr_reg(4'd14, 16'h0003, 2'b11, 1);
        run(15, 1);
        wr_reg(4'd14, 16'h0001, 2'b11, 1);

        // shadowed h_end while running, then immediate while stopped
        wait_model("wait_shadow", 3, 2);
        wr_reg(4'd3, 16'd5, 2'b11, 1);
        rd_chk("shadow_rd_pending", 4'd3, 16'd5);
        run(120, 1);
        wr_reg(4'd14, 16'h0000, 2'b11, 1);
        wr_reg(4'd3, 16'd2, 2'b11, 1);
        run(3, 1);
        wr_reg(4'd14, 16'h0001, 2'b11, 1);
        run(40, 1);
        wr_reg(4'd14, 16'h0000, 2'b11, 1);
        wr_reg(4'd3, 16'd9, 2'b11, 1);
        wr_reg(4'd14, 16'h0001, 2'b11, 1);
        run(60, 1);

        // interlace
        wr_reg(4'd14, 16'h0009, 2'b11, 1);
        n_f1 = 0; n_f0 = 0;
        for (int i = 0; i < 240; i++) begin
            tick(1);
            if (vcnt == 12'd5 && field) n_f1++;
            if (vcnt == 12'd5 && !field) n_f0++;
        end
        chk("il_v5_field1", {31'd0, n_f1 > 0}, 32'd1);
        chk("il_v5_field0", n_f0, 0);
        wr_reg(4'd14, 16'h0001, 2'b11, 1);
        run(120, 1);

        // line interrupt
        wr_reg(4'd15, 16'd2, 2'b11, 1);
        wr_reg(4'd14, 16'h0011, 2'b11, 1);
        wait_model("wait_irq_set", 1, 2);
        chk("irq_set", {31'd0, irq}, 32'd1);
        run(12, 1);
        chk("irq_held", {31'd0, irq}, 32'd1);
        rd_chk("irq_pending_rd", 4'd14, {m_field, 15'h4011});
        wr_reg(4'd14, 16'h4000, 2'b10, 1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        wait_model("wait_collide", 9, 1);
        chk("irq_before_collide", {31'd0, irq}, 32'd0);
        wr_reg(4'd14, 16'h4000, 2'b10, 1);
        chk("irq_collide_set_wins", {31'd0, irq}, 32'd1);
        run(5, 1);

        // asynchronous reset mid-frame
        wait_model("wait_reset_point", 6, 3);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_outs", {22'd0, ce_pixel, hblank, hsync, vblank, vsync, field, irq, 3'd0}, 32'd0);
        chk("midrst_cnt", {8'd0, hcnt, vcnt}, 32'd0);
        rd_chk("midrst_dout3", 4'd3, 16'd0);
        rd_chk("midrst_dout14", 4'd14, 16'd0);
        rd_chk("midrst_dout15", 4'd15, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(3, 0);
        chk("post_rst_idle", {8'd0, hcnt, vcnt}, 32'd0);
        wr_reg(4'd0, 16'd1, 2'b11, 0);
        wr_reg(4'd1, 16'd1, 2'b11, 0);
        wr_reg(4'd3, 16'd9, 2'b11, 0);
        wr_reg(4'd8, 16'd4, 2'b11, 0);
        run(4, 0);
        chk("post_rst_hold", {8'd0, hcnt, vcnt}, 32'd0);
        wr_reg(4'd14, 16'h0001, 2'b11, 0);
        run(14, 0);
        chk("post_rst_run", {8'd0, hcnt, vcnt}, {8'd0, 12'(m_h), 12'(m_v)});
        chk("post_rst_moved", {31'd0, (hcnt != 0) || (vcnt != 0)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
